hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 8 +
 rtl/sat_counter.sv | 13 +
 rtl/hazard_ctrl.sv | 62 ++++++
 tb/tb_hazard_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state and branch-type encodings for the pipeline hazard control.
package cpu_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, MEMWAIT = 2'd2, FLUSH = 2'd3} state_t;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_COND = 2'b01, BR_JUMP = 2'b10} br_t;
  function automatic logic is_taken(input logic [1:0] br, input logic dec);
    return br == BR_JUMP || (br == BR_COND && dec);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that clears synchronously and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (clear) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, memory-wait stall and branch flush control for the pipeline.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_writeregsel,
  input  logic             ex_write,
  input  logic             ex_wb_sel,
  input  logic [1:0]       branch,
  input  logic             branch_dec,
  input  logic             mem_busy,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             redirect,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [2:0] LOAD = 3'(FLUSH_CYCLES - 1);
  state_t cur, nxt;
  logic [2:0] cnt, cnt_nxt;
  logic taken, ld_hazard;
  assign taken = is_taken(branch, branch_dec) && (cur == RUN || cur == MEMWAIT);
  assign ld_hazard = ex_write && ex_wb_sel && ex_writeregsel != 5'd0 &&
                     ((id_rs1_used && id_rs1 == ex_writeregsel) || (id_rs2_used && id_rs2 == ex_writeregsel));
  always_ff @(posedge clk)
    if (rst) begin
      cur <= RUN;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  // The taken cycle itself is the first flush cycle, so FLUSH holds FLUSH_CYCLES-1 more.
  always_comb begin
    cnt_nxt = taken ? LOAD : (cur == FLUSH ? cnt - 3'(cnt != 3'd0) : cnt);
    nxt = cur;
    if (taken) nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    else if (cur == RUN) nxt = mem_busy ? MEMWAIT : (ld_hazard ? LDSTALL : RUN);
    else if (cur == LDSTALL) nxt = RUN;
    else if (cur == MEMWAIT) nxt = mem_busy ? MEMWAIT : RUN;
    else nxt = (cnt_nxt == 3'd0) ? RUN : FLUSH;
  end
  always_comb begin
    redirect = !rst && taken;
    flush = rst || taken || cur == FLUSH;
    stall = !rst && !taken && ((cur == RUN && (mem_busy || ld_hazard)) || (cur == MEMWAIT && mem_busy));
    bubble = !rst && !taken && cur == RUN && !mem_busy && ld_hazard;
    state = cur;
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .clear(rst), .inc(stall), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .clear(rst), .inc(redirect), .cnt(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (default build plus a FLUSH_CYCLES=1, 4-bit counter build).
module tb_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs1, id_rs2, ex_writeregsel;
  logic id_rs1_used, id_rs2_used, ex_write, ex_wb_sel, branch_dec, mem_busy;
  logic [1:0] branch;
  logic stall, bubble, flush, redirect, stall2, bubble2, flush2, redirect2;
  logic [1:0] state, state2;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0] stall_cnt2, flush_cnt2;
  int total = 0, bad = 0;

  typedef struct {
    string tag;
    logic [5:0] o;
    int sc;
    int fc;
    bit c2;
    logic [5:0] o2;
    int sc2;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_writeregsel(ex_writeregsel), .ex_write(ex_write),
    .ex_wb_sel(ex_wb_sel), .branch(branch), .branch_dec(branch_dec), .mem_busy(mem_busy),
    .stall(stall), .bubble(bubble), .flush(flush), .redirect(redirect), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_writeregsel(ex_writeregsel), .ex_write(ex_write),
    .ex_wb_sel(ex_wb_sel), .branch(branch), .branch_dec(branch_dec), .mem_busy(mem_busy),
    .stall(stall2), .bubble(bubble2), .flush(flush2), .redirect(redirect2), .state(state2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] wsel, input logic wr, input logic wb, input logic [1:0] br,
                     input logic dec, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_writeregsel = wsel; ex_write = wr; ex_wb_sel = wb;
    branch = br; branch_dec = dec; mem_busy = busy;
  endtask

  // Expected vector order: {stall, bubble, flush, redirect, state}; -1 skips a counter check.
  task automatic step(input string tag, input logic [5:0] o, input int sc = -1, input int fc = -1,
                      input bit c2 = 0, input logic [5:0] o2 = '0, input int sc2 = -1);
    exp_t e;
    logic [5:0] got;
    q.push_back('{tag, o, sc, fc, c2, o2, sc2});
    #1;
    e = q.pop_front();
    got = {stall, bubble, flush, redirect, state};
    total++;
    assert (got === e.o) else begin bad++; $error("FAIL %s outs: got %b want %b", e.tag, got, e.o); end
    if (e.sc >= 0) begin
      total++;
      assert (stall_cnt === 16'(e.sc)) else begin bad++; $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, stall_cnt, e.sc); end
    end
    if (e.fc >= 0) begin
      total++;
      assert (flush_cnt === 16'(e.fc)) else begin bad++; $error("FAIL %s flush_cnt: got %0d want %0d", e.tag, flush_cnt, e.fc); end
    end
    if (e.c2) begin
      got = {stall2, bubble2, flush2, redirect2, state2};
      total++;
      assert (got === e.o2) else begin bad++; $error("FAIL %s outs2: got %b want %b", e.tag, got, e.o2); end
      if (e.sc2 >= 0) begin
        total++;
        assert (stall_cnt2 === 4'(e.sc2)) else begin bad++; $error("FAIL %s stall_cnt2: got %0d want %0d", e.tag, stall_cnt2, e.sc2); end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    step("reset", 6'b001000, 0, 0, 1, 6'b001000, 0);
    rst = 0;
    step("idle", 6'b000000, 0, 0);
    drv(0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
    step("ld_rs2", 6'b110000, 0);
    step("ldstall_rs2", 6'b000001, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_ld", 6'b000000, 1);
    drv(7, 0, 1, 0, 7, 1, 1, 0, 0, 0);
    step("ld_rs1", 6'b110000, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("ldstall_rs1", 6'b000001, 2);
    drv(7, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step("src_unused", 6'b000000, 2);
    drv(7, 0, 1, 0, 7, 1, 0, 0, 0, 0);
    step("alu_producer", 6'b000000, 2);
    drv(7, 0, 1, 0, 7, 0, 1, 0, 0, 0);
    step("no_write", 6'b000000, 2);
    drv(0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    step("load_x0", 6'b000000, 2);
    step("load_x0_run", 6'b000000, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("cond_taken", 6'b001100, 2, 0, 1, 6'b001100);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("flush_2nd", 6'b001011, 2, 1, 1, 6'b000000);
    step("flush_done", 6'b000000, 2, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("cond_not_taken", 6'b000000, 2, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    step("reserved_br", 6'b000000, 2, 1);
    drv(5, 5, 1, 1, 5, 1, 1, 2, 0, 1);
    step("jump_ld_busy", 6'b001100, 2, 1);
    step("flush_ignores", 6'b001011, 2, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("jump_done", 6'b000000, 2, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("busy1", 6'b100000, 2);
    step("busy2", 6'b100010, 3);
    step("busy3", 6'b100010, 4);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("busy_release", 6'b000010, 5);
    step("busy_run", 6'b000000, 5, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("busy_a", 6'b100000, 5);
    drv(0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    step("memwait_jump", 6'b001110, 6, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("flush_busy", 6'b001011, 6, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("memwait_jump_done", 6'b000000, 6, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    step("jump_pre_rst", 6'b001100, 6, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    step("rst_in_flush", 6'b001011, 6, 4);
    rst = 0;
    step("post_rst", 6'b000000, 0, 0, 1, 6'b000000, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step("sat_busy", i == 0 ? 6'b100000 : 6'b100010, i);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_end", 6'b000010, 20, 0, 1, 6'b000010, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
